// File: rtl/snn_cfg_pkg.sv
// Shared configuration constants for the SNN core and its SPI register file.
package snn_cfg_pkg;

  // Register map
  localparam logic [3:0] AddrCtrl    = 4'h0;
  localparam logic [3:0] AddrW0      = 4'h1;
  localparam logic [3:0] AddrThresh  = 4'h9;
  localparam logic [3:0] AddrLeak    = 4'hA;
  localparam logic [3:0] AddrRefr    = 4'hB;
  localparam logic [3:0] AddrRsvdLo  = 4'hC;
  localparam logic [3:0] AddrStatus  = 4'hF;

  // CTRL register bits; commit and soft_clear are self-clearing strobes
  localparam int unsigned CtrlRunBit    = 0;
  localparam int unsigned CtrlCommitBit = 1;
  localparam int unsigned CtrlClearBit  = 2;

  // Shadow/active register slots: w0..w7, threshold, leak, refractory
  localparam int unsigned NumWeights = 8;
  localparam int unsigned NumShadow  = 11;
  localparam int unsigned IdxThresh  = 8;
  localparam int unsigned IdxLeak    = 9;
  localparam int unsigned IdxRefr    = 10;

  // Power-on neuron parameters
  localparam logic [7:0] DefWeight = 8'h00;
  localparam logic [7:0] DefThresh = 8'h40;
  localparam logic [7:0] DefLeak   = 8'h01;
  localparam logic [7:0] DefRefr   = 8'h02;

  // Default value of a shadow/active slot (slot = address - 1)
  function automatic logic [7:0] shadow_default(input int unsigned idx);
    case (idx)
      IdxThresh: shadow_default = DefThresh;
      IdxLeak:   shadow_default = DefLeak;
      IdxRefr:   shadow_default = DefRefr;
      default:   shadow_default = DefWeight;
    endcase
  endfunction

endpackage

// File: rtl/wr_edge_det.sv
// Rising-edge qualifier for the SPI slave's level write enable: one pulse per frame.
module wr_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic pulse
);

  logic we_q;

  // Registered copy of the level; resets high so a level held across reset is not a write
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q <= 1'b1;
    end else begin
      we_q <= level;
    end
  end

  // Pulse on the first cycle the level is seen high
  always_comb begin
    pulse = level & ~we_q;
  end

endmodule

// File: rtl/spi_cfg_regfile.sv
// SPI-written configuration register file: shadow/active neuron parameters with
// commit, soft clear, sticky write error, write counter and registered readback.
module spi_cfg_regfile
  import snn_cfg_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  wr_level,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_W-1:0]     rd_data,
  output logic [8*DATA_W-1:0]   weights,
  output logic [DATA_W-1:0]     threshold,
  output logic [DATA_W-1:0]     leak,
  output logic [DATA_W-1:0]     refractory,
  output logic                  run,
  output logic                  cfg_update,
  output logic                  wr_err,
  output logic [7:0]            wr_count
);

  logic              wr_accept;
  logic [DATA_W-1:0] shadow_q [NumShadow];
  logic [DATA_W-1:0] shadow_d [NumShadow];
  logic [DATA_W-1:0] active_q [NumShadow];
  logic [DATA_W-1:0] active_d [NumShadow];
  logic              run_q, run_d;
  logic              commit_q, commit_d;
  logic              cfg_update_q, cfg_update_d;
  logic              wr_err_q, wr_err_d;
  logic [7:0]        wr_count_q, wr_count_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  wr_edge_det u_wr_edge_det (
    .clk   (clk),
    .reset (reset),
    .level (wr_level),
    .pulse (wr_accept)
  );

  // Next-state for the register file: commit from the previous write, then the accepted write
  always_comb begin
    shadow_d     = shadow_q;
    active_d     = active_q;
    run_d        = run_q;
    wr_err_d     = wr_err_q;
    wr_count_d   = wr_count_q;
    commit_d     = 1'b0;
    cfg_update_d = 1'b0;

    if (commit_q) begin
      active_d     = shadow_q;
      cfg_update_d = 1'b1;
    end

    if (wr_accept) begin
      wr_count_d = wr_count_q + 8'd1;
      if (wr_addr == ADDR_W'(AddrCtrl)) begin
        if (wr_data[CtrlClearBit]) begin
          // Soft clear wins over commit and any commit still in flight
          for (int i = 0; i < NumShadow; i++) begin
            shadow_d[i] = DATA_W'(shadow_default(i));
            active_d[i] = DATA_W'(shadow_default(i));
          end
          run_d        = 1'b0;
          wr_err_d     = 1'b0;
          wr_count_d   = 8'd0;
          cfg_update_d = 1'b0;
        end else begin
          run_d    = wr_data[CtrlRunBit];
          commit_d = wr_data[CtrlCommitBit];
        end
      end else if (wr_addr >= ADDR_W'(AddrRsvdLo)) begin
        // Reserved and STATUS are not writable; data is dropped
        wr_err_d = 1'b1;
      end else begin
        for (int i = 0; i < NumShadow; i++) begin
          if (wr_addr == ADDR_W'(i + 1)) begin
            shadow_d[i] = wr_data;
          end
        end
      end
    end
  end

  // Readback mux over pre-write state, so a same-cycle write shows the old value
  always_comb begin
    rd_data_d = '0;
    if (rd_addr == ADDR_W'(AddrCtrl)) begin
      rd_data_d[CtrlRunBit] = run_q;
      rd_data_d[2]          = wr_err_q;
    end else if (rd_addr == ADDR_W'(AddrStatus)) begin
      rd_data_d[7:0] = {wr_count_q[6:0], wr_err_q};
    end else if (rd_addr < ADDR_W'(AddrRsvdLo)) begin
      for (int i = 0; i < NumShadow; i++) begin
        if (rd_addr == ADDR_W'(i + 1)) begin
          rd_data_d = shadow_q[i];
        end
      end
    end
  end

  // State registers; reset also drops a pending commit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NumShadow; i++) begin
        shadow_q[i] <= DATA_W'(shadow_default(i));
        active_q[i] <= DATA_W'(shadow_default(i));
      end
      run_q        <= 1'b0;
      commit_q     <= 1'b0;
      cfg_update_q <= 1'b0;
      wr_err_q     <= 1'b0;
      wr_count_q   <= 8'd0;
      rd_data_q    <= '0;
    end else begin
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      run_q        <= run_d;
      commit_q     <= commit_d;
      cfg_update_q <= cfg_update_d;
      wr_err_q     <= wr_err_d;
      wr_count_q   <= wr_count_d;
      rd_data_q    <= rd_data_d;
    end
  end

  // Drive outputs from the active set and status registers
  always_comb begin
    weights = '0;
    for (int i = 0; i < NumWeights; i++) begin
      weights[i*DATA_W +: DATA_W] = active_q[i];
    end
    threshold  = active_q[IdxThresh];
    leak       = active_q[IdxLeak];
    refractory = active_q[IdxRefr];
    run        = run_q;
    cfg_update = cfg_update_q;
    wr_err     = wr_err_q;
    wr_count   = wr_count_q;
    rd_data    = rd_data_q;
  end

endmodule

// File: tb/tb_spi_cfg_regfile.sv
// Directed bench for spi_cfg_regfile with hand-computed expectations.
module tb_spi_cfg_regfile;

  logic        clk;
  logic        reset;
  logic [3:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        wr_level;
  logic [3:0]  rd_addr;
  logic [7:0]  rd_data;
  logic [63:0] weights;
  logic [7:0]  threshold;
  logic [7:0]  leak;
  logic [7:0]  refractory;
  logic        run;
  logic        cfg_update;
  logic        wr_err;
  logic [7:0]  wr_count;

  int n_total = 0;
  int n_bad   = 0;
  int n_upd   = 0;
  logic [7:0] rd_val;

  spi_cfg_regfile #(
    .DATA_W (8),
    .ADDR_W (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_level   (wr_level),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .weights    (weights),
    .threshold  (threshold),
    .leak       (leak),
    .refractory (refractory),
    .run        (run),
    .cfg_update (cfg_update),
    .wr_err     (wr_err),
    .wr_count   (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count cycles with cfg_update high, sampled mid-cycle
  always @(negedge clk) begin
    if (cfg_update) n_upd++;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic spi_write(input logic [3:0] a, input logic [7:0] d, input int hold);
    wr_addr  = a;
    wr_data  = d;
    wr_level = 1'b1;
    repeat (hold) tick();
    wr_level = 1'b0;
    tick();
  endtask

  task automatic reg_read(input logic [3:0] a, output logic [7:0] d);
    rd_addr = a;
    tick();
    d = rd_data;
  endtask

  task automatic check_defaults(input string tag);
    check_eq({tag, "_weights"}, weights, 64'h0);
    check_eq({tag, "_thresh"}, threshold, 8'h40);
    check_eq({tag, "_leak"}, leak, 8'h01);
    check_eq({tag, "_refr"}, refractory, 8'h02);
    check_eq({tag, "_run"}, run, 1'b0);
    check_eq({tag, "_err"}, wr_err, 1'b0);
    check_eq({tag, "_count"}, wr_count, 8'h00);
  endtask

  initial begin
    reset    = 1'b1;
    wr_addr  = '0;
    wr_data  = '0;
    wr_level = 1'b0;
    rd_addr  = '0;
    repeat (3) tick();
    check_defaults("rst");
    check_eq("rst_upd", cfg_update, 1'b0);
    check_eq("rst_rd", rd_data, 8'h00);
    reset = 1'b0;
    repeat (2) tick();

    // Long-held level is a single write; active unchanged until commit
    spi_write(4'h9, 8'h55, 20);
    check_eq("hold_count", wr_count, 8'd1);
    check_eq("hold_thresh", threshold, 8'h40);
    reg_read(4'h9, rd_val);
    check_eq("hold_rd9", rd_val, 8'h55);
    check_eq("hold_noupd", n_upd, 0);

    // Commit with run
    spi_write(4'h1, 8'hA5, 1);
    check_eq("pre_commit_w0", weights[7:0], 8'h00);
    spi_write(4'h0, 8'h03, 1);
    repeat (3) tick();
    check_eq("commit_upd", n_upd, 1);
    check_eq("commit_weights", weights, 64'h00000000000000A5);
    check_eq("commit_thresh", threshold, 8'h55);
    check_eq("commit_run", run, 1'b1);
    check_eq("commit_count", wr_count, 8'd3);
    reg_read(4'h0, rd_val);
    check_eq("commit_rd_ctrl", rd_val, 8'h01);

    // Reserved write: sticky error, shadow untouched, still counted
    spi_write(4'hD, 8'hFF, 1);
    check_eq("rsvd_err", wr_err, 1'b1);
    check_eq("rsvd_count", wr_count, 8'd4);
    reg_read(4'h1, rd_val);
    check_eq("rsvd_rd1", rd_val, 8'hA5);
    reg_read(4'hF, rd_val);
    check_eq("rsvd_status", rd_val, 8'h09);
    reg_read(4'hD, rd_val);
    check_eq("rsvd_rdD", rd_val, 8'h00);
    reg_read(4'h0, rd_val);
    check_eq("rsvd_rd_ctrl", rd_val, 8'h05);
    spi_write(4'hA, 8'h09, 1);
    check_eq("err_sticky", wr_err, 1'b1);
    check_eq("err_count", wr_count, 8'd5);

    // Soft clear with run+clear
    spi_write(4'h0, 8'h06, 1);
    repeat (3) tick();
    check_defaults("clr");
    check_eq("clr_noupd", n_upd, 1);
    reg_read(4'h9, rd_val);
    check_eq("clr_rd9", rd_val, 8'h40);
    reg_read(4'hA, rd_val);
    check_eq("clr_rdA", rd_val, 8'h01);
    reg_read(4'h1, rd_val);
    check_eq("clr_rd1", rd_val, 8'h00);

    // Counter wrap after 256 accepted writes
    for (int i = 0; i < 256; i++) begin
      spi_write(4'h2, 8'(i), 1);
      if (i == 254) check_eq("wrap_ff", wr_count, 8'hFF);
    end
    check_eq("wrap_00", wr_count, 8'h00);
    reg_read(4'h2, rd_val);
    check_eq("wrap_rd2", rd_val, 8'hFF);

    // Write and readback of the same address in the same cycle
    rd_addr  = 4'h3;
    wr_addr  = 4'h3;
    wr_data  = 8'h77;
    wr_level = 1'b1;
    tick();
    check_eq("same_cyc_old", rd_data, 8'h00);
    wr_level = 1'b0;
    tick();
    check_eq("same_cyc_new", rd_data, 8'h77);
    check_eq("same_cyc_count", wr_count, 8'd1);

    // Clear overrides commit in the same write
    spi_write(4'h1, 8'h11, 1);
    spi_write(4'h0, 8'h07, 1);
    repeat (3) tick();
    check_eq("clr_commit_noupd", n_upd, 1);
    check_eq("clr_commit_w", weights, 64'h0);
    check_eq("clr_commit_run", run, 1'b0);
    check_eq("clr_commit_count", wr_count, 8'd0);
    reg_read(4'h3, rd_val);
    check_eq("clr_commit_rd3", rd_val, 8'h00);

    // Reset right after a commit write, level held across release
    spi_write(4'h1, 8'h33, 1);
    wr_addr  = 4'h0;
    wr_data  = 8'h03;
    wr_level = 1'b1;
    tick();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    repeat (4) tick();
    check_eq("abort_noupd", n_upd, 1);
    check_defaults("abort");
    reg_read(4'h1, rd_val);
    check_eq("abort_rd1", rd_val, 8'h00);
    wr_level = 1'b0;
    repeat (2) tick();
    check_eq("abort_count_after", wr_count, 8'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
